// File: rtl/painel_controlador.sv
// painel_controlador: sequencer for the LED panel row shift registers.
// Debounces the three panel buttons, runs the display mode FSM, drives the
// shared mode code and shift-enable pulse to the five row registers, scans
// the matrix rows and tracks the 16-step scroll offset.
//
// Ports:
//   CLK        system clock, all state changes on the rising edge
//   RST        asynchronous active-high reset
//   btn_parar  raw stop button (async, active-high)
//   btn_esq    raw right-to-left button (async, active-high)
//   btn_dir    raw left-to-right button (async, active-high)
//   ch0, ch1   mode code {ch1,ch0}: 00 load, 01 right-to-left, 10 left-to-right, 11 hold
//   desloca    one-cycle shift-enable pulse to all row registers
//   linhas     one-hot row enable
//   blank      forces LEDs off when 1
//   passo      current scroll offset 0..15
//   volta      one-cycle pulse on pattern wrap
//   estado     current FSM state (debug)
module painel_controlador #(
    parameter int unsigned DIV_SHIFT  = 12_500_000,
    parameter int unsigned DIV_SCAN   = 50_000,
    parameter int unsigned DEB_CYCLES = 500_000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       btn_parar,
    input  logic       btn_esq,
    input  logic       btn_dir,
    output logic       ch0,
    output logic       ch1,
    output logic       desloca,
    output logic [4:0] linhas,
    output logic       blank,
    output logic [3:0] passo,
    output logic       volta,
    output logic [1:0] estado
);

    localparam int unsigned SHIFT_W = (DIV_SHIFT > 1) ? $clog2(DIV_SHIFT) : 1;
    localparam int unsigned SCAN_W  = (DIV_SCAN > 1) ? $clog2(DIV_SCAN) : 1;
    localparam int unsigned DEB_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    localparam logic [SHIFT_W-1:0] SHIFT_LAST = SHIFT_W'(DIV_SHIFT - 1);
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(DIV_SCAN - 1);
    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEB_CYCLES - 1);

    // Button index: 0 = parar, 1 = esq, 2 = dir (also the priority order)
    localparam int unsigned NBTN = 3;

    typedef enum logic [1:0] {
        CARREGA = 2'b00,
        PARADO  = 2'b01,
        DIR_ESQ = 2'b10,
        ESQ_DIR = 2'b11
    } state_t;

    logic [NBTN-1:0]  btn_raw;
    logic [NBTN-1:0]  sync1;
    logic [NBTN-1:0]  sync2;
    logic [NBTN-1:0]  deb;
    logic [NBTN-1:0]  deb_q;
    logic [DEB_W-1:0] deb_cnt [NBTN];
    logic [NBTN-1:0]  evento;

    state_t             state;
    state_t             state_n;
    logic               fase;
    logic               fase_n;
    logic [SHIFT_W-1:0] div_cnt;
    logic [SHIFT_W-1:0] div_n;
    logic [3:0]         passo_n;
    logic               desloca_n;
    logic               volta_n;
    logic [1:0]         ch_n;
    logic               blank_n;

    logic [SCAN_W-1:0]  scan_cnt;

    assign btn_raw = {btn_dir, btn_esq, btn_parar};

    // Synchronizers and debounce counters; any low sample restarts the count
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_q <= '0;
            for (int i = 0; i < NBTN; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            deb_q <= deb;
            for (int i = 0; i < NBTN; i++) begin
                if (!sync2[i]) begin
                    deb_cnt[i] <= '0;
                    deb[i]     <= 1'b0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb[i] <= 1'b1;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
                end
            end
        end
    end

    // Press event: rising edge of the debounced level
    assign evento = deb & ~deb_q;

    // State and registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= CARREGA;
            fase       <= 1'b0;
            div_cnt    <= '0;
            passo      <= 4'd0;
            desloca    <= 1'b0;
            volta      <= 1'b0;
            {ch1, ch0} <= 2'b00;
            blank      <= 1'b1;
        end else begin
            state      <= state_n;
            fase       <= fase_n;
            div_cnt    <= div_n;
            passo      <= passo_n;
            desloca    <= desloca_n;
            volta      <= volta_n;
            {ch1, ch0} <= ch_n;
            blank      <= blank_n;
        end
    end

    // Next state; events are checked before the divider so a state change
    // always suppresses a pulse due in the same cycle
    always_comb begin
        state_n   = state;
        fase_n    = 1'b0;
        div_n     = div_cnt;
        passo_n   = passo;
        desloca_n = 1'b0;
        volta_n   = 1'b0;
        ch_n      = 2'b00;
        blank_n   = 1'b1;

        case (state)
            CARREGA: begin
                if (!fase) begin
                    fase_n    = 1'b1;
                    desloca_n = 1'b1;
                end else begin
                    state_n = PARADO;
                end
            end
            PARADO: begin
                if (evento[0]) begin
                    state_n = CARREGA;
                    passo_n = 4'd0;
                end else if (evento[1]) begin
                    state_n = DIR_ESQ;
                    div_n   = '0;
                end else if (evento[2]) begin
                    state_n = ESQ_DIR;
                    div_n   = '0;
                end
            end
            DIR_ESQ: begin
                if (evento[0]) begin
                    state_n = CARREGA;
                    passo_n = 4'd0;
                end else if (evento[2]) begin
                    state_n = ESQ_DIR;
                    div_n   = '0;
                end else if (div_cnt == SHIFT_LAST) begin
                    div_n     = '0;
                    desloca_n = 1'b1;
                    passo_n   = passo + 4'd1;
                    volta_n   = (passo == 4'd15);
                end else begin
                    div_n = div_cnt + SHIFT_W'(1);
                end
            end
            ESQ_DIR: begin
                if (evento[0]) begin
                    state_n = CARREGA;
                    passo_n = 4'd0;
                end else if (evento[1]) begin
                    state_n = DIR_ESQ;
                    div_n   = '0;
                end else if (div_cnt == SHIFT_LAST) begin
                    div_n     = '0;
                    desloca_n = 1'b1;
                    passo_n   = passo - 4'd1;
                    volta_n   = (passo == 4'd0);
                end else begin
                    div_n = div_cnt + SHIFT_W'(1);
                end
            end
            default: begin
                state_n = CARREGA;
            end
        endcase

        // Mode code and blank follow the state being entered
        case (state_n)
            CARREGA: begin
                ch_n    = 2'b00;
                blank_n = 1'b1;
            end
            PARADO: begin
                ch_n    = 2'b11;
                blank_n = 1'b1;
            end
            DIR_ESQ: begin
                ch_n    = 2'b01;
                blank_n = 1'b0;
            end
            ESQ_DIR: begin
                ch_n    = 2'b10;
                blank_n = 1'b0;
            end
            default: begin
                ch_n    = 2'b00;
                blank_n = 1'b1;
            end
        endcase
    end

    // Free-running row scan, independent of the display mode
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            scan_cnt <= '0;
            linhas   <= 5'b00001;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            linhas   <= {linhas[3:0], linhas[4]};
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

    assign estado = state;

endmodule

// File: tb/tb_painel_controlador.sv
// Testbench for painel_controlador with DIV_SHIFT=4, DIV_SCAN=3, DEB_CYCLES=2.
// Expected shift pulses are queued when buttons are driven and compared as
// the DUT pulses desloca; the row scan is tracked by a separate monitor.
module tb_painel_controlador;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       btn_parar = 1'b0;
    logic       btn_esq = 1'b0;
    logic       btn_dir = 1'b0;
    logic       ch0;
    logic       ch1;
    logic       desloca;
    logic [4:0] linhas;
    logic       blank;
    logic [3:0] passo;
    logic       volta;
    logic [1:0] estado;

    painel_controlador #(
        .DIV_SHIFT (4),
        .DIV_SCAN  (3),
        .DEB_CYCLES(2)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .btn_parar(btn_parar),
        .btn_esq  (btn_esq),
        .btn_dir  (btn_dir),
        .ch0      (ch0),
        .ch1      (ch1),
        .desloca  (desloca),
        .linhas   (linhas),
        .blank    (blank),
        .passo    (passo),
        .volta    (volta),
        .estado   (estado)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         cyc;
        logic [1:0] ch;
        logic [3:0] passo;
        logic       volta;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_exp(input int c, input logic [1:0] ch, input logic [3:0] p, input logic v);
        exp_t e;
        e.cyc   = c;
        e.ch    = ch;
        e.passo = p;
        e.volta = v;
        sb.push_back(e);
    endtask

    // Park at the falling edge inside cycle c
    task automatic goto_neg(input int c);
        @(negedge CLK);
        while (cyc < c) @(negedge CLK);
    endtask

    // Return just after the rising edge that starts cycle c
    task automatic drive_at(input int c);
        goto_neg(c - 1);
        @(posedge CLK);
        #1;
    endtask

    // Shift-pulse monitor: every desloca/volta must match the next queued entry
    always @(negedge CLK) begin
        if (!RST && (desloca || volta)) begin
            if (sb.size() == 0) begin
                check("pulse_unexpected", {30'd0, desloca, volta}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_desloca", desloca, 1);
                check("pulse_ch", {ch1, ch0}, e.ch);
                check("pulse_passo", passo, e.passo);
                check("pulse_volta", volta, e.volta);
            end
        end
    end

    // Row-scan monitor: each change is a left rotation, 3 cycles after the last
    logic [4:0] last_lin = 5'b00001;
    int         last_lin_cyc = 0;
    always @(negedge CLK) begin
        if (RST) begin
            last_lin     = 5'b00001;
            last_lin_cyc = cyc;
        end else if (linhas != last_lin) begin
            check("scan_period", cyc - last_lin_cyc, 3);
            check("scan_value", linhas, {last_lin[3:0], last_lin[4]});
            last_lin     = linhas;
            last_lin_cyc = cyc;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: stuck at cycle %0d, expected finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int r;
        int n;
        int p20;
        int d;
        int g;
        int m;
        int m2;
        int r2;

        // Reset values and the load sequence after release
        repeat (3) @(negedge CLK);
        check("rst_estado", estado, 0);
        check("rst_ch", {ch1, ch0}, 0);
        check("rst_desloca", desloca, 0);
        check("rst_volta", volta, 0);
        check("rst_blank", blank, 1);
        check("rst_linhas", linhas, 5'b00001);
        check("rst_passo", passo, 0);
        r = cyc;
        #2 RST = 1'b0;
        push_exp(r + 1, 2'b00, 4'd0, 1'b0);
        goto_neg(r + 1);
        check("load_estado", estado, 0);
        check("load_ch", {ch1, ch0}, 0);
        goto_neg(r + 2);
        check("idle_estado", estado, 1);
        check("idle_ch", {ch1, ch0}, 3);
        check("idle_blank", blank, 1);
        check("idle_passo", passo, 0);

        // Held esq: one event, right-to-left scroll through a wrap up to passo=5
        n = r + 4;
        drive_at(n);
        btn_esq = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            push_exp(n + 9 + 4 * k, 2'b01, 4'((k + 1) % 16), k == 15);
        end
        goto_neg(n + 4);
        check("esq_pre_estado", estado, 1);
        goto_neg(n + 5);
        check("esq_estado", estado, 2);
        check("esq_ch", {ch1, ch0}, 1);
        check("esq_blank", blank, 0);
        drive_at(n + 10);
        btn_esq = 1'b0;

        // dir event at passo=5: divider restarts, passo counts down through a wrap
        p20 = n + 89;
        d   = p20 + 2;
        for (int j = 0; j <= 5; j++) begin
            push_exp(d + 4 + 4 * j, 2'b10, 4'(4 - j), j == 5);
        end
        drive_at(p20 - 3);
        btn_dir = 1'b1;
        drive_at(p20);
        btn_dir = 1'b0;
        goto_neg(d - 1);
        check("dir_pre_estado", estado, 2);
        check("dir_pre_passo", passo, 5);
        goto_neg(d);
        check("dir_estado", estado, 3);
        check("dir_ch", {ch1, ch0}, 2);

        // parar landing on a cycle where a scroll pulse was due
        push_exp(d + 29, 2'b00, 4'd0, 1'b0);
        drive_at(d + 23);
        btn_parar = 1'b1;
        drive_at(d + 26);
        btn_parar = 1'b0;
        goto_neg(d + 28);
        check("stop_estado", estado, 0);
        check("stop_passo", passo, 0);
        check("stop_blank", blank, 1);
        goto_neg(d + 30);
        check("stop_idle_estado", estado, 1);
        check("stop_idle_ch", {ch1, ch0}, 3);

        // One-cycle glitch is rejected
        g = d + 32;
        drive_at(g);
        btn_esq = 1'b1;
        drive_at(g + 1);
        btn_esq = 1'b0;
        goto_neg(g + 8);
        check("glitch_estado", estado, 1);

        // Simultaneous esq and parar: parar wins
        m = g + 10;
        drive_at(m);
        btn_esq   = 1'b1;
        btn_parar = 1'b1;
        push_exp(m + 6, 2'b00, 4'd0, 1'b0);
        drive_at(m + 3);
        btn_esq   = 1'b0;
        btn_parar = 1'b0;
        goto_neg(m + 5);
        check("both_estado", estado, 0);
        goto_neg(m + 7);
        check("both_idle_estado", estado, 1);

        // Asynchronous reset mid-scroll
        m2 = m + 10;
        drive_at(m2);
        btn_esq = 1'b1;
        push_exp(m2 + 9, 2'b01, 4'd1, 1'b0);
        push_exp(m2 + 13, 2'b01, 4'd2, 1'b0);
        drive_at(m2 + 3);
        btn_esq = 1'b0;
        goto_neg(m2 + 14);
        check("pre_rst_passo", passo, 2);
        check("pre_rst_estado", estado, 2);
        @(posedge CLK);
        #3 RST = 1'b1;
        #1;
        check("arst_estado", estado, 0);
        check("arst_ch", {ch1, ch0}, 0);
        check("arst_blank", blank, 1);
        check("arst_passo", passo, 0);
        check("arst_linhas", linhas, 5'b00001);
        check("arst_desloca", desloca, 0);
        repeat (2) @(negedge CLK);
        r2 = cyc;
        #2 RST = 1'b0;
        push_exp(r2 + 1, 2'b00, 4'd0, 1'b0);
        goto_neg(r2 + 1);
        check("reload_estado", estado, 0);
        goto_neg(r2 + 2);
        check("reload_idle_estado", estado, 1);
        check("reload_idle_ch", {ch1, ch0}, 3);

        repeat (10) @(negedge CLK);
        check("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
